// File: rtl/if_id_hazard.sv
// if_id_hazard: LEGv8 fetch front end with PC, IF/ID register, load-use stall and branch flush
module if_id_hazard #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        imem_data,
  input  logic               imem_ready,
  input  logic               id_ex_memread,
  input  logic [4:0]         id_ex_write_reg,
  input  logic               branch_taken,
  input  logic [63:0]        branch_target,
  output logic [63:0]        pc_fetch,
  output logic [63:0]        if_id_pc,
  output logic [31:0]        if_id_instruction,
  output logic               if_id_valid,
  output logic               stall,
  output logic               flush,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] flush_count
);
  localparam logic [4:0] XZR = 5'd31;
  logic r_fmt, stur, cbz, b, uses_rn, uses_rm, uses_rt, hazard;
  // source-register decode of the instruction in IF/ID and load-use detection
  always_comb begin
    r_fmt   = if_id_instruction[28:24] == 5'b01010 || if_id_instruction[28:24] == 5'b01011;
    stur    = if_id_instruction[31:21] == 11'h7C0;
    cbz     = if_id_instruction[31:24] == 8'hB4;
    b       = if_id_instruction[31:26] == 6'b000101;
    uses_rn = !b && !cbz;
    uses_rm = r_fmt;
    uses_rt = stur || cbz;
    hazard  = if_id_valid && id_ex_memread && id_ex_write_reg != XZR &&
              ((uses_rn && if_id_instruction[9:5] == id_ex_write_reg) ||
               (uses_rm && if_id_instruction[20:16] == id_ex_write_reg) ||
               (uses_rt && if_id_instruction[4:0] == id_ex_write_reg));
    stall   = hazard && !branch_taken;
    flush   = branch_taken;
  end
  // PC: redirect beats stall, stall and fetch misses hold, otherwise advance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pc_fetch <= RESET_PC;
    else if (branch_taken) pc_fetch <= branch_target;
    else if (!stall && imem_ready) pc_fetch <= pc_fetch + 64'd4;
  end
  // IF/ID register: bubble on redirect or fetch miss, hold on stall
  always_ff @(posedge clock or posedge reset) begin
    if (reset || branch_taken) begin
      if_id_pc          <= '0;
      if_id_instruction <= '0;
      if_id_valid       <= 1'b0;
    end else if (stall) begin
      if_id_pc          <= if_id_pc;
      if_id_instruction <= if_id_instruction;
      if_id_valid       <= if_id_valid;
    end else if (!imem_ready) begin
      if_id_pc          <= '0;
      if_id_instruction <= '0;
      if_id_valid       <= 1'b0;
    end else begin
      if_id_pc          <= pc_fetch;
      if_id_instruction <= imem_data;
      if_id_valid       <= 1'b1;
    end
  end
  // saturating stall and flush event counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && stall_count != '1) stall_count <= stall_count + COUNT_W'(1);
      if (branch_taken && flush_count != '1) flush_count <= flush_count + COUNT_W'(1);
    end
  end
endmodule

// File: tb/tb_if_id_hazard.sv
// tb_if_id_hazard: directed bench with a behavioural reference model for if_id_hazard
module tb_if_id_hazard;
  localparam int CW = 2;
  localparam int SAT = (1 << CW) - 1;
  logic clock = 1'b0;
  logic reset;
  logic [31:0] imem_data;
  logic imem_ready, id_ex_memread, branch_taken;
  logic [4:0] id_ex_write_reg;
  logic [63:0] branch_target;
  logic [63:0] pc_fetch, if_id_pc;
  logic [31:0] if_id_instruction;
  logic if_id_valid, stall, flush;
  logic [CW-1:0] stall_count, flush_count;
  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  if_id_hazard #(.RESET_PC(64'h0), .COUNT_W(CW)) dut (
    .clock(clock), .reset(reset), .imem_data(imem_data), .imem_ready(imem_ready),
    .id_ex_memread(id_ex_memread), .id_ex_write_reg(id_ex_write_reg),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc_fetch(pc_fetch), .if_id_pc(if_id_pc), .if_id_instruction(if_id_instruction),
    .if_id_valid(if_id_valid), .stall(stall), .flush(flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_ins;
  logic m_v;
  int m_sc, m_fc;

  function automatic logic m_stall();
    logic [4:0] src[$];
    logic is_r, is_stur, is_cbz, is_b;
    is_r    = (m_ins[28:24] == 5'b01010) || (m_ins[28:24] == 5'b01011);
    is_stur = m_ins[31:21] == 11'h7C0;
    is_cbz  = m_ins[31:24] == 8'hB4;
    is_b    = m_ins[31:26] == 6'b000101;
    if (!is_b && !is_cbz) src.push_back(m_ins[9:5]);
    if (is_r) src.push_back(m_ins[20:16]);
    if (is_stur || is_cbz) src.push_back(m_ins[4:0]);
    m_stall = 1'b0;
    if (m_v && id_ex_memread && id_ex_write_reg != 5'd31 && !branch_taken)
      foreach (src[k]) if (src[k] == id_ex_write_reg) m_stall = 1'b1;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pc = 64'h0; m_ipc = 64'h0; m_ins = 32'h0; m_v = 1'b0; m_sc = 0; m_fc = 0;
    end else if (branch_taken) begin
      m_pc = branch_target; m_ipc = 64'h0; m_ins = 32'h0; m_v = 1'b0;
      m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
    end else if (m_stall()) begin
      m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
    end else if (!imem_ready) begin
      m_ipc = 64'h0; m_ins = 32'h0; m_v = 1'b0;
    end else begin
      m_ipc = m_pc; m_ins = imem_data; m_v = 1'b1; m_pc = m_pc + 64'd4;
    end
  end

  always @(negedge clock) if (chk_en) begin
    chk("pc_fetch", pc_fetch, m_pc);
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_instruction", 64'(if_id_instruction), 64'(m_ins));
    chk("if_id_valid", 64'(if_id_valid), 64'(m_v));
    chk("stall", 64'(stall), 64'(m_stall()));
    chk("flush", 64'(flush), 64'(branch_taken));
    chk("stall_count", 64'(stall_count), 64'(m_sc));
    chk("flush_count", 64'(flush_count), 64'(m_fc));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [31:0] ins);
    id_ex_memread = 1'b0;
    imem_data = ins;
    imem_ready = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; imem_data = 32'h8B030041; imem_ready = 1'b1; id_ex_memread = 1'b0;
    id_ex_write_reg = 5'd0; branch_taken = 1'b0; branch_target = 64'h0;
    #1 reset = 1'b1;
    #2;
    chk_en = 1'b1;
    chk("reset pc", pc_fetch, 64'h0);
    chk("reset valid", 64'(if_id_valid), 64'h0);
    chk("reset stall_count", 64'(stall_count), 64'h0);
    reset = 1'b0;
    tick();
    chk("run pc1", pc_fetch, 64'h4);
    chk("run if_id_pc1", if_id_pc, 64'h0);
    chk("run valid", 64'(if_id_valid), 64'h1);
    chk("run stall", 64'(stall), 64'h0);
    tick();
    chk("run pc2", pc_fetch, 64'h8);
    chk("run if_id_pc2", if_id_pc, 64'h4);
    load(32'h8B020025);
    imem_data = 32'h8B030041;
    id_ex_memread = 1'b1; id_ex_write_reg = 5'd1;
    #1 chk("loaduse stall", 64'(stall), 64'h1);
    tick();
    chk("loaduse pc hold", pc_fetch, 64'hC);
    chk("loaduse ins hold", 64'(if_id_instruction), 64'h8B020025);
    chk("loaduse stall_count", 64'(stall_count), 64'h1);
    id_ex_memread = 1'b0;
    #1 chk("resume stall", 64'(stall), 64'h0);
    tick();
    chk("resume pc", pc_fetch, 64'h10);
    chk("resume ins", 64'(if_id_instruction), 64'h8B030041);
    load(32'h8B0203E5);
    id_ex_memread = 1'b1; id_ex_write_reg = 5'd31;
    #1 chk("xzr no stall", 64'(stall), 64'h0);
    load(32'h14000020);
    id_ex_memread = 1'b1; id_ex_write_reg = 5'd1;
    #1 chk("B no stall", 64'(stall), 64'h0);
    load(32'hF8000041);
    id_ex_memread = 1'b1; id_ex_write_reg = 5'd1;
    #1 chk("STUR rt stall", 64'(stall), 64'h1);
    load(32'hB4000001);
    id_ex_memread = 1'b1; id_ex_write_reg = 5'd1;
    #1 chk("CBZ rt stall", 64'(stall), 64'h1);
    load(32'hB4000023);
    id_ex_memread = 1'b1; id_ex_write_reg = 5'd1;
    #1 chk("CBZ rn ignored", 64'(stall), 64'h0);
    id_ex_write_reg = 5'd3;
    #1 chk("CBZ rt3 stall", 64'(stall), 64'h1);
    branch_taken = 1'b1; branch_target = 64'h100;
    #1;
    chk("branch stall", 64'(stall), 64'h0);
    chk("branch flush", 64'(flush), 64'h1);
    tick();
    chk("branch pc", pc_fetch, 64'h100);
    chk("branch valid", 64'(if_id_valid), 64'h0);
    chk("branch flush_count", 64'(flush_count), 64'h1);
    chk("branch stall_count", 64'(stall_count), 64'h1);
    branch_taken = 1'b0; id_ex_memread = 1'b0; imem_ready = 1'b0;
    tick();
    chk("miss pc1", pc_fetch, 64'h100);
    chk("miss valid1", 64'(if_id_valid), 64'h0);
    tick();
    chk("miss pc2", pc_fetch, 64'h100);
    load(32'h8B020025);
    chk("refill pc", pc_fetch, 64'h104);
    chk("refill if_id_pc", if_id_pc, 64'h100);
    id_ex_memread = 1'b1; id_ex_write_reg = 5'd2; imem_ready = 1'b0;
    tick();
    chk("stall+miss valid", 64'(if_id_valid), 64'h1);
    chk("stall+miss ins", 64'(if_id_instruction), 64'h8B020025);
    chk("stall+miss pc", pc_fetch, 64'h104);
    chk("stall_count 2", 64'(stall_count), 64'h2);
    tick();
    chk("stall_count 3", 64'(stall_count), 64'h3);
    tick();
    chk("stall_count sat", 64'(stall_count), 64'h3);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async pc", pc_fetch, 64'h0);
    chk("async valid", 64'(if_id_valid), 64'h0);
    chk("async ins", 64'(if_id_instruction), 64'h0);
    chk("async stall_count", 64'(stall_count), 64'h0);
    chk("async stall", 64'(stall), 64'h0);
    reset = 1'b0; id_ex_memread = 1'b0; imem_ready = 1'b1; imem_data = 32'h8B030041;
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    chk("wrap target", pc_fetch, 64'hFFFF_FFFF_FFFF_FFFC);
    branch_taken = 1'b0;
    tick();
    chk("wrap pc", pc_fetch, 64'h0);
    chk("wrap if_id_pc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    branch_taken = 1'b1; branch_target = 64'h40;
    repeat (3) tick();
    chk("flush_count sat", 64'(flush_count), 64'h3);
    branch_taken = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_id_hazard.md
Name: if_id_hazard

Overview:
Fetch-side front end of the 5-stage LEGv8 pipeline. It holds the PC and the IF/ID pipeline register, and it detects load-use hazards against the ID/EX register outputs. It also applies branch redirects and flushes coming back from the MEM stage. It feeds the instruction and PC into the ID stage, and it drives the stall and flush controls that the ID/EX control-bubble muxes consume.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
COUNT_W, 32, width of the stall and flush performance counters.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
imem_data  input  32  instruction returned by instruction memory for pc_fetch.
imem_ready  input  1  imem_data is valid this cycle.
id_ex_memread  input  1  Memread output of the ID/EX register.
id_ex_write_reg  input  5  write_reg output of the ID/EX register.
branch_taken  input  1  branch resolved taken in MEM (Branch&zero or Uncond_Branch).
branch_target  input  64  target PC for a taken branch.
pc_fetch  output  64  current PC, used as the instruction-memory address.
if_id_pc  output  64  PC of the instruction held in IF/ID.
if_id_instruction  output  32  instruction held in IF/ID.
if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
stall  output  1  load-use stall; ID/EX control inputs are zeroed while high.
flush  output  1  equals branch_taken; downstream squashes ID/EX and EX/MEM controls.
stall_count  output  COUNT_W  count of stall cycles, saturating.
flush_count  output  COUNT_W  count of flush events, saturating.

Behaviour:
- Reset (async, any time, including mid-stall or mid-branch) forces:
  - pc=RESET_PC;
  - if_id_pc=0, if_id_instruction=0, if_id_valid=0;
  - stall_count=0, flush_count=0.
  - stall and flush are combinational and follow from the reset state: stall=0 because valid=0; flush=branch_taken.
- Source decode, applied to if_id_instruction (call it I):
  - R-format when I[28:24] is 5'b01010 or 5'b01011.
  - STUR when I[31:21]=11'h7C0.
  - CBZ when I[31:24]=8'hB4.
  - B when I[31:26]=6'b000101.
  - uses_rn = !B && !CBZ.
  - uses_rm = R-format.
  - uses_rt = STUR || CBZ.
- Load-use stall (combinational) is high when all of the following hold:
  - if_id_valid;
  - id_ex_memread;
  - id_ex_write_reg != 5'd31 (XZR is never a hazard);
  - the write register matches at least one used source: (uses_rn && I[9:5]==wr) || (uses_rm && I[20:16]==wr) || (uses_rt && I[4:0]==wr).
- stall output = hazard && !branch_taken.
- flush output = branch_taken.
- Per-edge update priority (highest first):
  1. branch_taken: pc<=branch_target; IF/ID<=bubble (valid 0, instruction 0, pc 0); flush_count++.
  2. stall: pc and IF/ID hold; stall_count++.
  3. !imem_ready: pc holds; IF/ID<=bubble.
  4. Normal: pc<=pc+4 (64-bit wrap-around, no overflow flag); if_id_instruction<=imem_data; if_id_pc<=pc; if_id_valid<=1.
- Latency: an instruction fetched at PC p appears in IF/ID one edge after imem_ready is sampled high at p.
- A load-use stall lasts exactly 1 cycle, because the bubble inserted into ID/EX clears id_ex_memread. Back-to-back dependent loads therefore stall 1 cycle each.
- A stall coincident with imem_ready=0 holds IF/ID; it does not bubble it.
- Both counters saturate at all-ones and never wrap.

Test Plan:
- Reset then free-run, RESET_PC=0, imem_ready=1, imem_data=ADD X1,X2,X3 (32'h8B030041) -> pc_fetch 0,4,8; if_id_pc 0 then 4; if_id_valid=1 after the first edge; stall=0.
- IF/ID holds ADD X5,X1,X2, id_ex_memread=1, id_ex_write_reg=1 -> stall=1 for one cycle; pc and IF/ID unchanged; stall_count=1. Next cycle with id_ex_memread=0 -> resumes.
- Same as above but id_ex_write_reg=31, and separately IF/ID=B with a matching Rn field -> stall=0 in both cases.
- STUR X1,[X2,#0] in IF/ID, load writing X1 -> stall=1 (Rt hazard). CBZ X1 -> stall=1; Rn field is ignored.
- branch_taken=1, branch_target=64'h100, with a hazard present at the same time -> stall=0, flush=1; next edge pc=0x100, if_id_valid=0, flush_count=1, stall_count unchanged.
- Toggle imem_ready=0 for 2 cycles -> pc holds and IF/ID shows bubbles; assert reset mid-stall -> all outputs return to reset values immediately, without waiting for a clock edge.
